// File: rtl/int_ctrl_if.sv
// Bus bundle between the interrupt controller and its surroundings:
// peripheral done lines and CPU handshake in, request/vector/status out.
interface int_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             done1;
  logic             done2;
  logic             done3;
  logic             done4;
  logic [3:0]       mask;
  logic             int_ack;
  logic             eoi;
  logic             interrupt;
  logic [31:0]      int_addr;
  logic [1:0]       int_id;
  logic [3:0]       pending;
  logic             busy;
  logic [CNT_W-1:0] drop_cnt;

  // Side that produces events and CPU handshakes
  modport master (
    output done1, done2, done3, done4, mask, int_ack, eoi,
    input  interrupt, int_addr, int_id, pending, busy, drop_cnt
  );

  // The controller itself
  modport slave (
    input  done1, done2, done3, done4, mask, int_ack, eoi,
    output interrupt, int_addr, int_id, pending, busy, drop_cnt
  );
endinterface

// File: rtl/int_ctrl.sv
// Four-source fixed-priority interrupt controller. Rising edges on the done
// lines latch pending bits; the lowest-index enabled pending source is
// presented to the CPU as a registered request plus ISR vector, held until
// acknowledged, and no new arbitration happens until end-of-interrupt.
module int_ctrl #(
  parameter logic [31:0] ISR_BASE   = 32'h0000_0100,
  parameter logic [31:0] ISR_STRIDE = 32'h0000_0010,
  parameter int          CNT_W      = 8
) (
  input logic       clk,
  input logic       reset,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       prev_q;
  logic [3:0]       pending_q, pending_d;
  logic [CNT_W-1:0] dropCnt_q, dropCnt_d;
  logic             interrupt_q, interrupt_d;
  logic [1:0]       intId_q, intId_d;
  logic [31:0]      intAddr_q, intAddr_d;

  logic [3:0]       doneVec;
  logic [3:0]       evt;
  logic [3:0]       clr;
  logic [3:0]       eligible;
  logic [1:0]       winner;
  logic             coalesce;

  assign doneVec  = {bus.done4, bus.done3, bus.done2, bus.done1};
  assign evt      = doneVec & ~prev_q;
  assign eligible = pending_q & bus.mask;

  // Fixed priority: the lowest set index among eligible sources wins
  always_comb begin
    winner = 2'd3;
    if (eligible[0])      winner = 2'd0;
    else if (eligible[1]) winner = 2'd1;
    else if (eligible[2]) winner = 2'd2;
  end

  // Request FSM: arbitrate in IDLE, hold the request in REQ, wait for eoi
  always_comb begin
    state_d     = state_q;
    interrupt_d = interrupt_q;
    intId_d     = intId_q;
    intAddr_d   = intAddr_q;
    clr         = 4'b0000;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          intId_d     = winner;
          intAddr_d   = ISR_BASE + (32'(winner) * ISR_STRIDE);
          interrupt_d = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          interrupt_d  = 1'b0;
          clr[intId_q] = 1'b1;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pending latch (a new event beats a same-cycle clear) and dropped-event count
  always_comb begin
    pending_d = (pending_q & ~clr) | evt;
    coalesce  = |(evt & pending_q & ~clr);
    dropCnt_d = dropCnt_q;
    if (coalesce && (dropCnt_q != {CNT_W{1'b1}})) begin
      dropCnt_d = dropCnt_q + CNT_W'(1);
    end
  end

  // State and datapath registers; reset drops everything, including latched events
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      prev_q      <= 4'b0000;
      pending_q   <= 4'b0000;
      dropCnt_q   <= '0;
      interrupt_q <= 1'b0;
      intId_q     <= 2'd0;
      intAddr_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      prev_q      <= doneVec;
      pending_q   <= pending_d;
      dropCnt_q   <= dropCnt_d;
      interrupt_q <= interrupt_d;
      intId_q     <= intId_d;
      intAddr_q   <= intAddr_d;
    end
  end

  assign bus.interrupt = interrupt_q;
  assign bus.int_addr  = intAddr_q;
  assign bus.int_id    = intId_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: a cycle-by-cycle vector table for the
// basic request/ack/eoi flow, then hand-written sequences for holding,
// coalescing, counter saturation and asynchronous reset.
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] done;
  logic [3:0] mask;
  logic       int_ack;
  logic       eoi;

  int passCount  = 0;
  int checkCount = 0;

  int_ctrl_if #(.CNT_W(8)) busA ();
  int_ctrl_if #(.CNT_W(2)) busB ();

  assign busA.done1   = done[0];
  assign busA.done2   = done[1];
  assign busA.done3   = done[2];
  assign busA.done4   = done[3];
  assign busA.mask    = mask;
  assign busA.int_ack = int_ack;
  assign busA.eoi     = eoi;

  assign busB.done1   = done[0];
  assign busB.done2   = done[1];
  assign busB.done3   = done[2];
  assign busB.done4   = done[3];
  assign busB.mask    = mask;
  assign busB.int_ack = int_ack;
  assign busB.eoi     = eoi;

  int_ctrl #(.ISR_BASE(32'h0000_0100), .ISR_STRIDE(32'h0000_0010), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  int_ctrl #(.ISR_BASE(32'h0000_0100), .ISR_STRIDE(32'h0000_0010), .CNT_W(2)) dutSat (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  done;
    logic [3:0]  mask;
    logic        ack;
    logic        eoi;
    logic        expIrq;
    logic        expBusy;
    logic [3:0]  expPend;
    logic [1:0]  expId;
    logic [31:0] expAddr;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] addr;
  } expReq_t;

  vec_t    vecs[$];
  expReq_t sbQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic [3:0] m,
                               input logic a, input logic e);
    done    = d;
    mask    = m;
    int_ack = a;
    eoi     = e;
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    sbQ.delete();
  endtask

  task automatic expectReq(input logic [1:0] id);
    expReq_t e;
    e.id   = id;
    e.addr = 32'h100 + 32'(id) * 32'h10;
    sbQ.push_back(e);
  endtask

  // Bounded wait for a request, then compare it against the scoreboard head
  task automatic waitIrq(input string name, input int budget);
    expReq_t e;
    int n = 0;
    while (busA.interrupt !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, " request seen"}, 32'(busA.interrupt), 32'h1);
    if (sbQ.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL %s scoreboard: got request id %0h, expected none", name, busA.int_id);
    end else begin
      e = sbQ.pop_front();
      checkOutput({name, " int_id"}, 32'(busA.int_id), 32'(e.id));
      checkOutput({name, " int_addr"}, busA.int_addr, e.addr);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
    #1;

    // Reset state while reset is held
    checkOutput("reset interrupt", 32'(busA.interrupt), 32'h0);
    checkOutput("reset busy", 32'(busA.busy), 32'h0);
    checkOutput("reset pending", 32'(busA.pending), 32'h0);
    checkOutput("reset int_addr", busA.int_addr, 32'h0);
    checkOutput("reset drop_cnt", 32'(busA.drop_cnt), 32'h0);

    //                done  mask  ack   eoi   irq   busy  pend  id    addr
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 32'h000});
    vecs.push_back(vec_t'{4'h2, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 2'd0, 32'h000});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 2'd1, 32'h110});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 2'd1, 32'h110});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 2'd1, 32'h110});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'd1, 32'h110});
    vecs.push_back(vec_t'{4'h9, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 2'd1, 32'h110});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 2'd0, 32'h100});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 2'd0, 32'h100});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h8, 2'd0, 32'h100});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 2'd3, 32'h130});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 2'd3, 32'h130});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'd3, 32'h130});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'd3, 32'h130});
    vecs.push_back(vec_t'{4'h1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 2'd3, 32'h130});
    vecs.push_back(vec_t'{4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 2'd3, 32'h130});
    vecs.push_back(vec_t'{4'h0, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd3, 32'h130});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 2'd0, 32'h100});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0, 32'h100});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 32'h100});
    vecs.push_back(vec_t'{4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 32'h100});

    tick();
    reset = 1'b1;

    // Vector table: one clock per row, outputs compared after that edge
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].done, vecs[i].mask, vecs[i].ack, vecs[i].eoi);
      tick();
      checkOutput($sformatf("vec%0d interrupt", i), 32'(busA.interrupt), 32'(vecs[i].expIrq));
      checkOutput($sformatf("vec%0d busy", i), 32'(busA.busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d pending", i), 32'(busA.pending), 32'(vecs[i].expPend));
      checkOutput($sformatf("vec%0d int_id", i), 32'(busA.int_id), 32'(vecs[i].expId));
      checkOutput($sformatf("vec%0d int_addr", i), busA.int_addr, vecs[i].expAddr);
    end
    checkOutput("vec drop_cnt", 32'(busA.drop_cnt), 32'h0);

    // Held request: masking the active source must not retract or retarget it
    doReset();
    applyStimulus(4'h4, 4'hF, 1'b0, 1'b0);
    expectReq(2'd2);
    tick();
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
    waitIrq("hold", 5);
    applyStimulus(4'h0, 4'hB, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("hold%0d interrupt", i), 32'(busA.interrupt), 32'h1);
      checkOutput($sformatf("hold%0d int_addr", i), busA.int_addr, 32'h120);
    end
    applyStimulus(4'h0, 4'hB, 1'b1, 1'b0);
    tick();
    checkOutput("hold ack interrupt", 32'(busA.interrupt), 32'h0);
    checkOutput("hold ack pending2", 32'(busA.pending[2]), 32'h0);
    checkOutput("hold ack busy", 32'(busA.busy), 32'h1);
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b1);
    tick();
    checkOutput("hold eoi busy", 32'(busA.busy), 32'h0);

    // Coalescing: three done3 pulses before ack give one service, two drops
    doReset();
    expectReq(2'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'h4, 4'hF, 1'b0, 1'b0);
      tick();
      applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
      tick();
    end
    checkOutput("coalesce drop_cnt", 32'(busA.drop_cnt), 32'h2);
    checkOutput("coalesce drop_cnt w2", 32'(busB.drop_cnt), 32'h2);
    waitIrq("coalesce", 5);
    applyStimulus(4'h0, 4'hF, 1'b1, 1'b0);
    tick();
    checkOutput("coalesce ack pending", 32'(busA.pending), 32'h0);
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b1);
    tick();
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("coalesce single service irq", 32'(busA.interrupt), 32'h0);
    checkOutput("coalesce single service busy", 32'(busA.busy), 32'h0);

    // Event on the same edge as ack of that source survives the clear
    expectReq(2'd2);
    applyStimulus(4'h4, 4'hF, 1'b0, 1'b0);
    tick();
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
    waitIrq("setwins", 5);
    applyStimulus(4'h4, 4'hF, 1'b1, 1'b0);
    tick();
    checkOutput("setwins pending", 32'(busA.pending), 32'h4);
    checkOutput("setwins interrupt", 32'(busA.interrupt), 32'h0);
    checkOutput("setwins drop_cnt", 32'(busA.drop_cnt), 32'h2);
    expectReq(2'd2);
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b1);
    tick();
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
    waitIrq("setwins rearb", 5);

    // Six more coalesced edges: 8-bit counter counts, 2-bit counter saturates
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'h4, 4'hF, 1'b0, 1'b0);
      tick();
      applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
      tick();
    end
    checkOutput("saturate drop_cnt w8", 32'(busA.drop_cnt), 32'h8);
    checkOutput("saturate drop_cnt w2", 32'(busB.drop_cnt), 32'h3);

    // Asynchronous reset in SERVICE, with done1 held high across release
    doReset();
    expectReq(2'd0);
    applyStimulus(4'h1, 4'hF, 1'b0, 1'b0);
    tick();
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
    waitIrq("areset", 5);
    applyStimulus(4'h1, 4'hF, 1'b0, 1'b0);
    tick();
    applyStimulus(4'h0, 4'hF, 1'b1, 1'b0);
    tick();
    applyStimulus(4'h2, 4'hF, 1'b0, 1'b0);
    tick();
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
    checkOutput("areset pre busy", 32'(busA.busy), 32'h1);
    checkOutput("areset pre pending", 32'(busA.pending), 32'h2);
    checkOutput("areset pre drop_cnt", 32'(busA.drop_cnt), 32'h1);
    #2;
    reset = 1'b0;
    done  = 4'h1;
    #1;
    checkOutput("areset interrupt", 32'(busA.interrupt), 32'h0);
    checkOutput("areset busy", 32'(busA.busy), 32'h0);
    checkOutput("areset pending", 32'(busA.pending), 32'h0);
    checkOutput("areset drop_cnt", 32'(busA.drop_cnt), 32'h0);
    checkOutput("areset int_addr", busA.int_addr, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("release edge1 pending", 32'(busA.pending), 32'h1);
    checkOutput("release edge1 interrupt", 32'(busA.interrupt), 32'h0);
    tick();
    checkOutput("release edge2 interrupt", 32'(busA.interrupt), 32'h1);
    checkOutput("release edge2 int_id", 32'(busA.int_id), 32'h0);
    checkOutput("release edge2 int_addr", busA.int_addr, 32'h100);
    applyStimulus(4'h1, 4'hF, 1'b1, 1'b0);
    tick();
    applyStimulus(4'h1, 4'hF, 1'b0, 1'b1);
    tick();
    applyStimulus(4'h1, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("release single event irq", 32'(busA.interrupt), 32'h0);
    checkOutput("release single event pending", 32'(busA.pending), 32'h0);
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
